// File: rtl/viterbi_ber_checker.sv
// Bit-error-rate checker for a Viterbi decoder: searches the decoder latency against a
// reference bit history, locks on a clean window, then counts compared bits and mismatches.
module viterbi_ber_checker #(
    parameter int unsigned MAX_LAT  = 64,
    parameter int unsigned WIN      = 32,
    parameter int unsigned LOCK_THR = 2,
    parameter int unsigned LOSS_THR = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ref_valid_i,
    input  logic        ref_bit_i,
    input  logic        dec_valid_i,
    input  logic        dec_bit_i,
    input  logic        clear_i,
    output logic        locked_o,
    output logic [7:0]  latency_o,
    output logic [31:0] bit_cnt_o,
    output logic [31:0] err_cnt_o,
    output logic        err_pulse_o
);

    localparam int unsigned FillW = $clog2(MAX_LAT + 1);
    localparam int unsigned WinW  = $clog2(WIN + 1);
    localparam int unsigned IdxW  = $clog2(MAX_LAT);

    typedef enum logic {StSearch, StLocked} state_e;

    state_e             state_q, state_d;
    logic [MAX_LAT-1:0] hist_q, hist_d;
    logic [FillW-1:0]   fill_q, fill_d;
    logic [7:0]         lat_q, lat_d;
    logic [WinW-1:0]    win_cnt_q, win_cnt_d;
    logic [WinW-1:0]    win_err_q, win_err_d;
    logic [31:0]        bit_cnt_q, bit_cnt_d;
    logic [31:0]        err_cnt_q, err_cnt_d;
    logic               err_pulse_q, err_pulse_d;

    logic               cmp_valid;
    logic               mismatch;
    logic               win_done;
    logic [WinW-1:0]    win_cnt_inc;
    logic [WinW-1:0]    win_err_inc;

    // The candidate tap is only meaningful once more than L ref samples have arrived.
    assign cmp_valid   = dec_valid_i && (32'(fill_q) > 32'(lat_q));
    assign mismatch    = cmp_valid && (dec_bit_i != hist_q[lat_q[IdxW-1:0]]);
    assign win_cnt_inc = win_cnt_q + WinW'(1);
    assign win_err_inc = win_err_q + WinW'(mismatch);
    assign win_done    = cmp_valid && (32'(win_cnt_inc) == WIN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StSearch;
            hist_q      <= '0;
            fill_q      <= '0;
            lat_q       <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            bit_cnt_q   <= '0;
            err_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            lat_q       <= lat_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            bit_cnt_q   <= bit_cnt_d;
            err_cnt_q   <= err_cnt_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    // Window decision: the WIN-th sample and its mismatch are part of the verdict.
    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        win_cnt_d = win_cnt_q;
        win_err_d = win_err_q;
        if (cmp_valid) begin
            if (win_done) begin
                win_cnt_d = '0;
                win_err_d = '0;
                unique case (state_q)
                    StSearch: begin
                        if (32'(win_err_inc) <= LOCK_THR) begin
                            state_d = StLocked;
                        end else if (32'(lat_q) == MAX_LAT - 1) begin
                            lat_d = '0;
                        end else begin
                            lat_d = lat_q + 8'd1;
                        end
                    end
                    StLocked: begin
                        if (32'(win_err_inc) > LOSS_THR) begin
                            state_d = StSearch;
                        end
                    end
                    default: state_d = StSearch;
                endcase
            end else begin
                win_cnt_d = win_cnt_inc;
                win_err_d = win_err_inc;
            end
        end
    end

    always_comb begin
        hist_d      = ref_valid_i ? {hist_q[MAX_LAT-2:0], ref_bit_i} : hist_q;
        fill_d      = (ref_valid_i && (32'(fill_q) != MAX_LAT)) ? fill_q + FillW'(1) : fill_q;
        bit_cnt_d   = bit_cnt_q;
        err_cnt_d   = err_cnt_q;
        err_pulse_d = 1'b0;
        if (cmp_valid && (state_q == StLocked)) begin
            err_pulse_d = mismatch;
            if (bit_cnt_q != '1) begin
                bit_cnt_d = bit_cnt_q + 32'd1;
            end
            if (mismatch && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + 32'd1;
            end
        end
        // Clear wins over a same-cycle increment; the pulse is unaffected.
        if (clear_i) begin
            bit_cnt_d = '0;
            err_cnt_d = '0;
        end
    end

    always_comb begin
        locked_o    = (state_q == StLocked);
        latency_o   = lat_q;
        bit_cnt_o   = bit_cnt_q;
        err_cnt_o   = err_cnt_q;
        err_pulse_o = err_pulse_q;
    end

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Self-checking bench: random streams against a queue-based reference of the lock/BER rules.
module tb_viterbi_ber_checker;

    localparam int MAX_LAT  = 64;
    localparam int WIN      = 32;
    localparam int LOCK_THR = 2;
    localparam int LOSS_THR = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ref_valid_i = 1'b0;
    logic        ref_bit_i = 1'b0;
    logic        dec_valid_i = 1'b0;
    logic        dec_bit_i = 1'b0;
    logic        clear_i = 1'b0;
    logic        locked_o;
    logic [7:0]  latency_o;
    logic [31:0] bit_cnt_o;
    logic [31:0] err_cnt_o;
    logic        err_pulse_o;

    viterbi_ber_checker #(
        .MAX_LAT (MAX_LAT),
        .WIN     (WIN),
        .LOCK_THR(LOCK_THR),
        .LOSS_THR(LOSS_THR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ref_valid_i(ref_valid_i),
        .ref_bit_i  (ref_bit_i),
        .dec_valid_i(dec_valid_i),
        .dec_bit_i  (dec_bit_i),
        .clear_i    (clear_i),
        .locked_o   (locked_o),
        .latency_o  (latency_o),
        .bit_cnt_o  (bit_cnt_o),
        .err_cnt_o  (err_cnt_o),
        .err_pulse_o(err_pulse_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;

    // Reference model: all ref bits ever seen since reset, plus lock/window bookkeeping.
    bit          refs[$];
    bit          m_locked;
    int          m_lat, m_wc, m_we;
    logic [31:0] m_bit, m_err;
    bit          m_pulse;
    int          prev_lat;
    bit          saw_wrap;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        refs.delete();
        m_locked = 0; m_lat = 0; m_wc = 0; m_we = 0;
        m_bit = '0; m_err = '0; m_pulse = 0;
    endtask

    task automatic model_step(input bit rv, input bit rb, input bit dv, input bit db,
                              input bit clr);
        bit cmp, mis;
        int n;
        n   = refs.size();
        cmp = dv && (n > m_lat);
        mis = cmp ? (db ^ refs[n-1-m_lat]) : 1'b0;
        m_pulse = cmp && m_locked && mis;
        if (cmp && m_locked) begin
            if (m_bit != 32'hFFFF_FFFF) m_bit = m_bit + 1;
            if (mis && m_err != 32'hFFFF_FFFF) m_err = m_err + 1;
        end
        if (clr) begin
            m_bit = '0;
            m_err = '0;
        end
        if (cmp) begin
            m_wc++;
            m_we += int'(mis);
            if (m_wc == WIN) begin
                if (!m_locked) begin
                    if (m_we <= LOCK_THR) m_locked = 1;
                    else m_lat = (m_lat + 1) % MAX_LAT;
                end else if (m_we > LOSS_THR) begin
                    m_locked = 0;
                end
                m_wc = 0;
                m_we = 0;
            end
        end
        if (rv) refs.push_back(rb);
    endtask

    task automatic compare();
        chk("locked_o", 32'(locked_o), 32'(m_locked));
        chk("latency_o", 32'(latency_o), 32'(m_lat));
        chk("bit_cnt_o", bit_cnt_o, m_bit);
        chk("err_cnt_o", err_cnt_o, m_err);
        chk("err_pulse_o", 32'(err_pulse_o), 32'(m_pulse));
        if (prev_lat == MAX_LAT - 1 && latency_o == 8'd0) saw_wrap = 1;
        prev_lat = int'(latency_o);
    endtask

    // One clock: decoder emits the ref bit D+1 samples back (tap hist[D]), optionally flipped.
    task automatic tick(input int d, input bit flip, input bit rv, input bit dv, input bit clr);
        bit rb, db;
        int n;
        rb = 1'($urandom);
        n  = refs.size();
        db = ((n > d) ? refs[n-1-d] : 1'($urandom)) ^ flip;
        ref_valid_i = rv;
        ref_bit_i   = rb;
        dec_valid_i = dv;
        dec_bit_i   = db;
        clear_i     = clr;
        model_step(rv, rb, dv, db, clr);
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic run_clean(input int d, input int n);
        for (int i = 0; i < n; i++) tick(d, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must drop before any clock edge.
    task automatic do_reset();
        #2;
        ref_valid_i = 0; dec_valid_i = 0; clear_i = 0;
        rst = 1'b0;
        #1;
        chk("rst_locked", 32'(locked_o), 32'd0);
        chk("rst_latency", 32'(latency_o), 32'd0);
        chk("rst_bit_cnt", bit_cnt_o, 32'd0);
        chk("rst_err_cnt", err_cnt_o, 32'd0);
        chk("rst_pulse", 32'(err_pulse_o), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        compare();
    endtask

    initial begin
        logic [31:0] err0;
        int guard;
        model_reset();
        prev_lat = 0;
        saw_wrap = 0;
        do_reset();

        // Clean stream at delay 5: six windows (L=0..5) to lock.
        run_clean(5, 200);
        chk("lock_d5_locked", 32'(locked_o), 32'd1);
        chk("lock_d5_latency", 32'(latency_o), 32'd5);
        chk("lock_d5_err", err_cnt_o, 32'd0);

        // One flip in 16 while locked: four errors, lock held.
        err0 = err_cnt_o;
        for (int i = 0; i < 64; i++) tick(5, (i % 16) == 0, 1'b1, 1'b1, 1'b0);
        chk("flip16_err_delta", err_cnt_o - err0, 32'd4);
        chk("flip16_locked", 32'(locked_o), 32'd1);

        // Align to a window start, then 12 corrupted bits inside one window.
        guard = 0;
        while (m_wc != 0 && guard < 64) begin
            run_clean(5, 1);
            guard++;
        end
        chk("align_window", 32'(m_wc), 32'd0);
        for (int i = 0; i < 32; i++) tick(5, i < 12, 1'b1, 1'b1, 1'b0);
        chk("burst_unlocked", 32'(locked_o), 32'd0);
        chk("burst_latency", 32'(latency_o), 32'd5);
        run_clean(5, 40);
        chk("relock_locked", 32'(locked_o), 32'd1);
        chk("relock_latency", 32'(latency_o), 32'd5);

        // Clear in the same cycle as a locked mismatch.
        tick(5, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("clr_err_cnt", err_cnt_o, 32'd0);
        chk("clr_bit_cnt", bit_cnt_o, 32'd0);
        chk("clr_pulse", 32'(err_pulse_o), 32'd1);
        chk("clr_locked", 32'(locked_o), 32'd1);
        run_clean(5, 10);

        // Saturation of the bit counter.
        force dut.bit_cnt_q = 32'hFFFF_FFFC;
        #1;
        release dut.bit_cnt_q;
        m_bit = 32'hFFFF_FFFC;
        run_clean(5, 8);
        chk("bit_cnt_sat", bit_cnt_o, 32'hFFFF_FFFF);
        chk("sat_locked", 32'(locked_o), 32'd1);
        do_reset();

        // True delay at the top of the search range.
        run_clean(MAX_LAT - 1, 2200);
        chk("lock_d63_locked", 32'(locked_o), 32'd1);
        chk("lock_d63_latency", 32'(latency_o), 32'(MAX_LAT - 1));
        do_reset();

        // Uncorrelated decoder output drives the search through L=63 and back to 0.
        saw_wrap = 0;
        for (int i = 0; i < 2150; i++) tick(3, 1'($urandom), 1'b1, 1'b1, 1'b0);
        chk("search_wrapped", 32'(saw_wrap), 32'd1);
        run_clean(3, 2200);
        chk("lock_d3_latency", 32'(latency_o), 32'd3);
        chk("lock_d3_locked", 32'(locked_o), 32'd1);
        do_reset();

        // Random valids, sparse error bursts and occasional clears.
        for (int i = 0; i < 3000; i++) begin
            tick(7, ($urandom_range(0, 19) == 0) || ((i % 700) > 680),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 199) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/viterbi_ber_checker.md
VITERBI_BER_CHECKER -- requirements
Module: viterbi_ber_checker

Interface
REQ-001 Parameter MAX_LAT, default 64, SHALL set the number of candidate decoder latencies searched, 0..MAX_LAT-1 (legal range 2..255).
REQ-002 Parameter WIN, default 32, SHALL set the number of compared decoded bits in one evaluation window.
REQ-003 Parameter LOCK_THR, default 2, SHALL set the maximum mismatches in a SEARCH window that still allows lock.
REQ-004 Parameter LOSS_THR, default 8, SHALL set the mismatch count in a LOCKED window above which lock is lost.
REQ-005 clk  input  1  SHALL be the clock.
REQ-006 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-007 ref_valid_i  input  1  SHALL qualify ref_bit_i.
REQ-008 ref_bit_i  input  1  SHALL carry the source bit, as fed to the convolutional encoder.
REQ-009 dec_valid_i  input  1  SHALL qualify dec_bit_i.
REQ-010 dec_bit_i  input  1  SHALL carry the Viterbi decoder output bit.
REQ-011 clear_i  input  1  SHALL zero the statistics counters, synchronously.
REQ-012 locked_o  output  1  SHALL be high while in LOCKED.
REQ-013 latency_o  output  8  SHALL give the current candidate or locked latency L, counted in ref samples.
REQ-014 bit_cnt_o  output  32  SHALL give the number of bits compared while LOCKED.
REQ-015 err_cnt_o  output  32  SHALL give the number of mismatches counted while LOCKED.
REQ-016 err_pulse_o  output  1  SHALL give a one-cycle pulse per LOCKED mismatch.

Function
REQ-017 A MAX_LAT-bit history SHALL shift on each ref_valid_i cycle; hist[0] is the newest ref bit.
REQ-018 A dec_valid_i cycle SHALL compare dec_bit_i with hist[L] as registered before any same-cycle shift.
REQ-019 A fill counter SHALL count ref samples, saturating at MAX_LAT; a comparison with fill <= L SHALL be ignored (not compared, not counted).
REQ-020 The FSM SHALL have exactly two states, SEARCH and LOCKED; win_cnt counts compared samples and win_err counts mismatches.
REQ-021 In SEARCH, when win_cnt reaches WIN: if win_err <= LOCK_THR, go to LOCKED with L held; otherwise L = L+1, wrapping from MAX_LAT-1 to 0, and stay in SEARCH. Both cases clear win_cnt and win_err.
REQ-022 In LOCKED, each valid comparison SHALL increment bit_cnt_o, and a mismatch SHALL also increment err_cnt_o.
REQ-023 err_pulse_o SHALL assert in the cycle after a LOCKED mismatch; it is registered with one-cycle latency.
REQ-024 In LOCKED, when win_cnt reaches WIN: if win_err > LOSS_THR, go to SEARCH with L unchanged; otherwise stay in LOCKED. Both cases clear the window counters.
REQ-025 SEARCH comparisons SHALL NOT change bit_cnt_o, err_cnt_o or err_pulse_o.
REQ-026 bit_cnt_o and err_cnt_o SHALL saturate at 32'hFFFFFFFF.
REQ-027 clear_i SHALL take priority over a same-cycle increment: the counter becomes 0 and that sample is lost.
REQ-028 clear_i SHALL NOT affect the FSM state, L, the history or the window counters.
REQ-029 Simultaneous ref_valid_i and dec_valid_i SHALL be legal, and both SHALL be processed in the same cycle.
REQ-030 The window decision SHALL take effect on the cycle the WIN-th compared sample arrives, and that sample's mismatch SHALL be included.
REQ-031 locked_o and latency_o SHALL be driven directly from registers.

Reset
REQ-032 While rst is low, the block SHALL hold: state SEARCH; L=0; fill=0; history, window counters, bit_cnt_o, err_cnt_o, err_pulse_o and locked_o all 0.
REQ-033 Asserting rst mid-operation SHALL abandon any lock immediately, and the first clean window after release SHALL restart the search at L=0.

Verification
REQ-034 Clean stream with decoder delay 5, ref and dec valid every cycle, PRBS data -> locked_o=1 with latency_o=5 after 6 windows; err_cnt_o=0.
REQ-035 Locked at L=5, flip 1 in 16 dec bits -> err_cnt_o increments by 1 per flip, err_pulse_o one cycle after each flip, lock held (2 per window <= LOSS_THR).
REQ-036 Locked, then 12 consecutive corrupted dec bits inside one window -> locked_o=0 at that window end, latency_o=5, relock after the next clean window.
REQ-037 True delay MAX_LAT-1 with default parameters (63) -> search wraps correctly, locks at latency_o=63; a corrupt start that passes L=63 wraps to L=0.
REQ-038 clear_i asserted in the same cycle as a LOCKED mismatch -> err_cnt_o=0 next cycle, err_pulse_o still 1, locked_o unchanged.
REQ-039 Preload bit_cnt_o near 32'hFFFFFFFF via a force, then continue locked -> bit_cnt_o holds at all-ones; rst low mid-lock -> all outputs 0 within the same cycle, asynchronously.
